// File: rtl/fft_pkg.sv
// Shared defaults and state type for the FFT stage sequencer.
package fft_pkg;

    localparam int unsigned LOG2N_DEF   = 4;
    localparam int unsigned MEM_LAT_DEF = 1;
    localparam int unsigned BFU_LAT_DEF = 2;

    localparam int unsigned N_DEF      = 1 << LOG2N_DEF;
    localparam int unsigned HALF_N_DEF = N_DEF / 2;
    localparam int unsigned D_DEF      = MEM_LAT_DEF + BFU_LAT_DEF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth register shift line with asynchronous clear.
module fft_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe_q;
    logic [DEPTH-1:0][WIDTH-1:0] pipe_d;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = din;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_ctrl.sv
// Radix-2 DIT stage sequencer: issues one butterfly per cycle, drains the
// RAM + butterfly pipeline between stages, and replays addresses for write-back.
module fft_stage_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N   = LOG2N_DEF,
    parameter int unsigned MEM_LAT = MEM_LAT_DEF,
    parameter int unsigned BFU_LAT = BFU_LAT_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(LOG2N)-1:0]   stage,
    output logic                       rd_en,
    output logic [LOG2N-1:0]           rd_addr_a,
    output logic [LOG2N-1:0]           rd_addr_b,
    output logic [LOG2N-2:0]           tw_addr,
    output logic                       wr_en,
    output logic [LOG2N-1:0]           wr_addr_a,
    output logic [LOG2N-1:0]           wr_addr_b
);

    localparam int unsigned HALF_N = (1 << LOG2N) / 2;
    localparam int unsigned D      = MEM_LAT + BFU_LAT;
    localparam int unsigned SW     = $clog2(LOG2N);
    localparam int unsigned KW     = LOG2N - 1;
    localparam int unsigned DW     = (D > 1) ? $clog2(D) : 1;
    localparam int unsigned LW     = 1 + 2 * LOG2N;

    state_e             state_q, state_d;
    logic [SW-1:0]      stage_q, stage_d;
    logic [SW-1:0]      stage_out_q, stage_out_d;
    logic [KW-1:0]      k_q, k_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic               rd_en_q, rd_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [LOG2N-1:0]   rd_addr_a_q, rd_addr_a_d;
    logic [LOG2N-1:0]   rd_addr_b_q, rd_addr_b_d;
    logic [KW-1:0]      tw_q, tw_d;
    logic [LOG2N-1:0]   span, pos, grp;
    logic [LW-1:0]      wr_bus;

    always_comb begin
        span = LOG2N'(1) << stage_q;
        pos  = {1'b0, k_q} & (span - LOG2N'(1));
        grp  = {1'b0, k_q} >> stage_q;
    end

    // Read-side outputs are registered from the current state, so they trail
    // the state register by one cycle; stage is delayed to stay aligned.
    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        k_d         = k_q;
        drain_d     = drain_q;
        rd_en_d     = 1'b0;
        rd_addr_a_d = '0;
        rd_addr_b_d = '0;
        tw_d        = '0;
        busy_d      = (state_q != S_IDLE);
        done_d      = (state_q == S_DONE);
        stage_out_d = stage_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    stage_d = '0;
                    k_d     = '0;
                end
            end
            S_RUN: begin
                rd_en_d     = 1'b1;
                rd_addr_a_d = ((grp << stage_q) << 1) | pos;
                rd_addr_b_d = rd_addr_a_d + span;
                tw_d        = KW'(pos << (KW - stage_q));
                k_d         = k_q + KW'(1);
                if (k_q == KW'(HALF_N - 1)) begin
                    k_d     = '0;
                    drain_d = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + DW'(1);
                if (drain_q == DW'(D - 1)) begin
                    drain_d = '0;
                    if (stage_q == SW'(LOG2N - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        stage_d = stage_q + SW'(1);
                        k_d     = '0;
                        state_d = S_RUN;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            stage_q     <= '0;
            k_q         <= '0;
            drain_q     <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            tw_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stage_out_q <= '0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            k_q         <= k_d;
            drain_q     <= drain_d;
            rd_en_q     <= rd_en_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            tw_q        <= tw_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stage_out_q <= stage_out_d;
        end
    end

    fft_delay_line #(
        .WIDTH (LW),
        .DEPTH (D)
    ) u_wr_dly (
        .clk     (clk),
        .reset_n (reset_n),
        .din     ({rd_en_q, rd_addr_a_q, rd_addr_b_q}),
        .dout    (wr_bus)
    );

    assign {wr_en, wr_addr_a, wr_addr_b} = wr_bus;

    assign busy      = busy_q;
    assign done      = done_q;
    assign stage     = stage_out_q;
    assign rd_en     = rd_en_q;
    assign rd_addr_a = rd_addr_a_q;
    assign rd_addr_b = rd_addr_b_q;
    assign tw_addr   = tw_q;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Self-checking bench: per-cycle schedule model of the FFT sequencer plus a
// read-after-pending-write scoreboard, driven by directed and random starts/resets.
module tb_fft_stage_ctrl;

    localparam int L    = 4;
    localparam int N    = 1 << L;
    localparam int HALF = N / 2;
    localparam int D    = 3;
    localparam int P    = HALF + D;
    localparam int MAXC = 2000;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic         busy;
    logic         done;
    logic [1:0]   stage;
    logic         rd_en;
    logic [L-1:0] rd_addr_a;
    logic [L-1:0] rd_addr_b;
    logic [L-2:0] tw_addr;
    logic         wr_en;
    logic [L-1:0] wr_addr_a;
    logic [L-1:0] wr_addr_b;

    fft_stage_ctrl #(
        .LOG2N   (L),
        .MEM_LAT (1),
        .BFU_LAT (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .stage     (stage),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = index of the most recent rising edge; outputs after edge c belong to cycle c
    int cyc = -1;
    always @(posedge clk) cyc <= cyc + 1;

    int e_rd [MAXC];
    int e_a  [MAXC];
    int e_b  [MAXC];
    int e_tw [MAXC];
    int e_wr [MAXC];
    int e_wa [MAXC];
    int e_wb [MAXC];
    int e_busy [MAXC];
    int e_done [MAXC];
    int e_stage[MAXC];
    int pend [N];
    int next_free;
    int n_checks;
    int n_errors;
    bit mon_en;
    int mon_c;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic clear_from(input int c);
        for (int i = c; i < MAXC; i++) begin
            if (i >= 0) begin
                e_rd[i] = 0; e_a[i] = 0; e_b[i] = 0; e_tw[i] = 0;
                e_wr[i] = 0; e_wa[i] = 0; e_wb[i] = 0;
                e_busy[i] = 0; e_done[i] = 0; e_stage[i] = 0;
            end
        end
        for (int i = 0; i < N; i++) pend[i] = -1;
        next_free = 0;
    endtask

    // Whole-run schedule from a start accepted at edge t0: each stage is
    // N/2 reads then D idle cycles; writes mirror reads D cycles later.
    task automatic plan_run(input int t0);
        int span, grp, pos, a, r, fin;
        fin = t0 + L * P + 1;
        for (int s = 0; s < L; s++) begin
            span = 1 << s;
            for (int k = 0; k < HALF; k++) begin
                grp = k / span;
                pos = k % span;
                a   = grp * 2 * span + pos;
                r   = t0 + 1 + s * P + k;
                if (r + D < MAXC) begin
                    e_rd[r] = 1; e_a[r] = a; e_b[r] = a + span;
                    e_tw[r] = pos * (N / (2 * span));
                    e_wr[r + D] = 1; e_wa[r + D] = a; e_wb[r + D] = a + span;
                end
            end
        end
        for (int c = t0 + 1; c < MAXC; c++) begin
            e_busy[c]  = (c <= fin) ? 1 : 0;
            e_done[c]  = (c == fin) ? 1 : 0;
            e_stage[c] = (c - t0 - 1) / P;
            if (e_stage[c] > L - 1) e_stage[c] = L - 1;
        end
        next_free = fin + 1;
    endtask

    task automatic tick(input bit st);
        @(posedge clk);
        #1;
        start = st;
        if (st && (cyc + 1) >= next_free) plan_run(cyc + 1);
    endtask

    task automatic reset_pulse(input int n);
        @(posedge clk);
        #1;
        start   = 1'b0;
        reset_n = 1'b0;
        clear_from(cyc);
        repeat (n) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en && cyc >= 0 && cyc < MAXC) begin
            mon_c = cyc;
            check("rd_en",     32'(rd_en),     32'(e_rd[mon_c]));
            check("rd_addr_a", 32'(rd_addr_a), 32'(e_a[mon_c]));
            check("rd_addr_b", 32'(rd_addr_b), 32'(e_b[mon_c]));
            check("tw_addr",   32'(tw_addr),   32'(e_tw[mon_c]));
            check("wr_en",     32'(wr_en),     32'(e_wr[mon_c]));
            check("wr_addr_a", 32'(wr_addr_a), 32'(e_wa[mon_c]));
            check("wr_addr_b", 32'(wr_addr_b), 32'(e_wb[mon_c]));
            check("busy",      32'(busy),      32'(e_busy[mon_c]));
            check("done",      32'(done),      32'(e_done[mon_c]));
            check("stage",     32'(stage),     32'(e_stage[mon_c]));
            if (rd_en === 1'b1) begin
                check("hazard_a", 32'(pend[rd_addr_a] < mon_c), 32'd1);
                check("hazard_b", 32'(pend[rd_addr_b] < mon_c), 32'd1);
                pend[rd_addr_a] = mon_c + D;
                pend[rd_addr_b] = mon_c + D;
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        mon_en   = 1'b0;
        start    = 1'b0;
        reset_n  = 1'b1;
        clear_from(0);
        #2;
        reset_n = 1'b0;
        mon_en  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // single run with a stray start pulse during stage 0
        tick(1'b1);
        repeat (9) tick(1'b0);
        tick(1'b1);
        repeat (45) tick(1'b0);

        // start held high: back-to-back runs
        repeat (120) tick(1'b1);
        repeat (50) tick(1'b0);

        // reset in the middle of a run, then a fresh run
        tick(1'b1);
        repeat (19) tick(1'b0);
        reset_pulse(2);
        tick(1'b1);
        repeat (50) tick(1'b0);

        // random starts with rare asynchronous resets
        repeat (600) begin
            if ($urandom_range(0, 149) == 0) reset_pulse(int'($urandom_range(1, 3)));
            else tick($urandom_range(0, 9) == 0);
        end
        repeat (50) tick(1'b0);

        @(posedge clk);
        #1;
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
